// File: rtl/wb_stage.sv
// MEM/WB segment register and writeback mux: load extraction, register-file write port,
// and commit pulse/PC/instruction/counter for the trace path.
module wb_stage #(
  parameter int WIDTH   = 32,
  parameter int DEPTH_B = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_pc,
  input  logic [WIDTH-1:0]   in_inst,
  input  logic [WIDTH-1:0]   in_alu_res,
  input  logic [WIDTH-1:0]   in_mem_rd,
  input  logic [WIDTH-1:0]   in_pc_add4,
  input  logic [1:0]         in_wb_sel,
  input  logic [2:0]         in_ld_type,
  input  logic [DEPTH_B-1:0] in_rf_wa,
  input  logic               in_rf_we,
  output logic [DEPTH_B-1:0] rf_wa,
  output logic               rf_we,
  output logic [WIDTH-1:0]   rf_wd,
  output logic               commit,
  output logic [WIDTH-1:0]   commit_pc,
  output logic [WIDTH-1:0]   commit_inst,
  output logic [31:0]        commit_cnt
);

  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_LOAD = 2'd1, WB_PC4 = 2'd2, WB_ZERO = 2'd3} wb_sel_e;
  localparam logic [2:0] LD_LH = 3'd1, LD_LB = 3'd2, LD_LHU = 3'd3, LD_LBU = 3'd4;

  logic               valid_q, valid_d, fresh_q, fresh_d, rf_we_q, rf_we_d;
  logic [WIDTH-1:0]   pc_q, pc_d, inst_q, inst_d, alu_res_q, alu_res_d;
  logic [WIDTH-1:0]   mem_rd_q, mem_rd_d, pc_add4_q, pc_add4_d;
  logic [1:0]         wb_sel_q, wb_sel_d;
  logic [2:0]         ld_type_q, ld_type_d;
  logic [DEPTH_B-1:0] rf_wa_q, rf_wa_d;
  logic [31:0]        commit_cnt_q, commit_cnt_d;

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latch).
    valid_d   = valid_q;   fresh_d  = 1'b0;      pc_d      = pc_q;
    inst_d    = inst_q;    alu_res_d = alu_res_q; mem_rd_d = mem_rd_q;
    pc_add4_d = pc_add4_q; wb_sel_d = wb_sel_q;  ld_type_d = ld_type_q;
    rf_wa_d   = rf_wa_q;   rf_we_d  = rf_we_q;
    if (flush) begin
      valid_d   = 1'b0;    pc_d     = '0;        inst_d    = '0;
      alu_res_d = '0;      mem_rd_d = '0;        pc_add4_d = '0;
      wb_sel_d  = '0;      ld_type_d = '0;       rf_wa_d   = '0;
      rf_we_d   = 1'b0;
    end else if (en) begin
      valid_d   = in_valid;   fresh_d  = 1'b1;      pc_d      = in_pc;
      inst_d    = in_inst;    alu_res_d = in_alu_res; mem_rd_d = in_mem_rd;
      pc_add4_d = in_pc_add4; wb_sel_d = in_wb_sel;  ld_type_d = in_ld_type;
      rf_wa_d   = in_rf_wa;   rf_we_d  = in_rf_we;
    end
    commit_cnt_d = commit_cnt_q + {31'd0, commit};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0; fresh_q  <= 1'b0; pc_q      <= '0; inst_q  <= '0;
      alu_res_q <= '0;   mem_rd_q <= '0;   pc_add4_q <= '0; wb_sel_q <= '0;
      ld_type_q <= '0;   rf_wa_q  <= '0;   rf_we_q   <= 1'b0;
      commit_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;   fresh_q  <= fresh_d;  pc_q      <= pc_d;
      inst_q    <= inst_d;    alu_res_q <= alu_res_d; mem_rd_q <= mem_rd_d;
      pc_add4_q <= pc_add4_d; wb_sel_q <= wb_sel_d; ld_type_q <= ld_type_d;
      rf_wa_q   <= rf_wa_d;   rf_we_q  <= rf_we_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  logic [1:0]       off;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] ld_val;

  always_comb begin
    off = alu_res_q[1:0];
    case (off)
      2'd0:    ld_byte = mem_rd_q[7:0];
      2'd1:    ld_byte = mem_rd_q[15:8];
      2'd2:    ld_byte = mem_rd_q[23:16];
      default: ld_byte = mem_rd_q[31:24];
    endcase
    // Halfword ignores off[0]: misaligned halves silently read the enclosing aligned half.
    ld_half = off[1] ? mem_rd_q[31:16] : mem_rd_q[15:0];
    case (ld_type_q)
      LD_LH:   ld_val = {{(WIDTH-16){ld_half[15]}}, ld_half};
      LD_LB:   ld_val = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      LD_LHU:  ld_val = {{(WIDTH-16){1'b0}}, ld_half};
      LD_LBU:  ld_val = {{(WIDTH-8){1'b0}}, ld_byte};
      default: ld_val = mem_rd_q;
    endcase
    case (wb_sel_e'(wb_sel_q))
      WB_ALU:  rf_wd = alu_res_q;
      WB_LOAD: rf_wd = ld_val;
      WB_PC4:  rf_wd = pc_add4_q;
      default: rf_wd = '0;
    endcase
  end

  // x0 writes are dropped here because the register file forwards on any address match.
  assign rf_we       = valid_q & rf_we_q & (rf_wa_q != '0);
  assign rf_wa       = rf_wa_q;
  assign commit      = valid_q & fresh_q;
  assign commit_pc   = pc_q;
  assign commit_inst = inst_q;
  assign commit_cnt  = commit_cnt_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB segment register plus writeback mux of the pipelined CPU.
- Captures MEM-stage results, extracts and extends load data, selects the writeback value, and drives the register-file write port (rf_wa/rf_we/rf_wd) directly.
- Also emits a one-shot commit pulse, the committed PC/instruction, and a commit counter for the debug/trace path.

Parameters:
- WIDTH, 32, datapath width (must be 32; byte/halfword extraction assumes it)
- DEPTH_B, 5, register address width

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- en  input  1  segment enable; 0 = stall (hold contents)
- flush  input  1  insert bubble
- in_valid  input  1  MEM-stage instruction valid
- in_pc  input  WIDTH  instruction PC
- in_inst  input  WIDTH  instruction word
- in_alu_res  input  WIDTH  ALU result / memory address
- in_mem_rd  input  WIDTH  raw aligned word read from data memory
- in_pc_add4  input  WIDTH  PC+4 (link value)
- in_wb_sel  input  2  0 ALU, 1 load, 2 PC+4, 3 zero
- in_ld_type  input  3  0 LW, 1 LH, 2 LB, 3 LHU, 4 LBU, 5-7 treated as LW
- in_rf_wa  input  DEPTH_B  destination register
- in_rf_we  input  1  destination write request
- rf_wa  output  DEPTH_B  to register-file write address
- rf_we  output  1  to register-file write enable
- rf_wd  output  WIDTH  to register-file write data
- commit  output  1  one-cycle pulse per retired instruction
- commit_pc  output  WIDTH  PC of the instruction in WB
- commit_inst  output  WIDTH  instruction word in WB
- commit_cnt  output  32  retired-instruction count

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous, active-high. All state updates occur on the posedge of `clk`.
- Update priority at each posedge: rst > flush > en > hold.
  - rst: all segment registers and commit_cnt go to 0; valid=0, fresh=0.
  - flush (en ignored): valid=0, fresh=0, all other segment registers 0.
  - en=1: capture every in_* field; valid=in_valid; fresh=1.
  - en=0: all fields hold; fresh=0.
- Outputs are derived combinationally from the segment registers. Latency is 1 cycle from MEM inputs to WB outputs.
- Outputs after reset: rf_we=0, rf_wa=0, rf_wd=0, commit=0, commit_pc=0, commit_inst=0, commit_cnt=0.
- rf_we = valid & rf_we_q & (rf_wa_q != 0).
  - Writes to x0 are suppressed here because the register file forwards rf_wd on any rf_we address match, including x0.
- rf_wa = rf_wa_q.
- rf_wd is selected by wb_sel_q:
  - 0: alu_res_q
  - 1: load value
  - 2: pc_add4_q
  - 3: 0
  - rf_wd is driven even when rf_we=0 (don't-care for the consumer, but deterministic).
- Load extraction uses off = alu_res_q[1:0], little-endian:
  - Byte: mem_rd_q[8*off+7 : 8*off]
  - Halfword: uses off[1] only (off[0] ignored, no misalignment trap); 0 gives [15:0], 1 gives [31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Stall: a held instruction keeps rf_we asserted every cycle. Rewriting the same value is harmless and required, so bypassing stays correct during a stall.
- commit = valid & fresh. An instruction produces exactly one pulse regardless of how long it is stalled in WB.
- commit_cnt increments by 1 on each posedge where commit=1 and rst=0. It wraps from 0xFFFFFFFF to 0.
- commit_pc/commit_inst equal pc_q/inst_q (0 after rst or flush).
- Reset mid-stall or mid-flush: rst wins; the next cycle shows all outputs at their reset values.
- Simultaneous flush and en=1 with in_valid=1: the input is discarded; no commit and no write.

Test Plan:
- Reset, then en=1, in_valid=1, wb_sel=0, alu_res=0x12345678, wa=5, we=1 → next cycle rf_we=1, rf_wa=5, rf_wd=0x12345678, commit=1, commit_cnt becomes 1 after the following edge.
- Load with mem_rd=0x80FF7F01, wb_sel=1, swept over types/offsets:
  - LB off=3 → 0xFFFFFF80
  - LBU off=3 → 0x00000080
  - LB off=0 → 0x00000001
  - LH off=2 → 0xFFFF80FF
  - LHU off=2 → 0x000080FF
  - LH off=0 → 0x00007F01
  - LW → 0x80FF7F01
- wa=0, we=1, alu_res=0xDEAD → rf_we=0 and commit=1. Also wb_sel=2 with pc_add4=0x1C → rf_wd=0x1C.
- Load an instruction, then hold en=0 for 3 cycles → rf_we stays 1 all 4 cycles, commit pulses only in the first, commit_cnt increments by exactly 1.
- flush=1 together with en=1 and a valid input → next cycle rf_we=0, commit=0, commit_pc=0. Assert rst during a stall → all outputs 0 on the next cycle, commit_cnt=0.
- Preload commit_cnt to 0xFFFFFFFF by forcing or by iteration, then commit one instruction → commit_cnt=0.
